ysyx_24090003_dmem_responder: RTL and testbench



---
 rtl/ysyx_24090003_dmem_responder_pkg.sv | 34 +++
 rtl/ysyx_24090003_sram_array.sv | 25 ++
 rtl/ysyx_24090003_dmem_responder.sv | 129 ++++++++++++
 tb/tb_ysyx_24090003_dmem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090003_dmem_responder_pkg.sv
// Shared width codes and lane helpers for the data-memory responder.
package ysyx_24090003_dmem_responder_pkg;

    localparam logic [2:0] WM_BYTE = 3'b001;
    localparam logic [2:0] WM_HALF = 3'b011;
    localparam logic [2:0] WM_WORD = 3'b111;

    // Byte-lane enables for an access of width code wmask starting at lane off.
    function automatic logic [3:0] lane_mask(input logic [2:0] wmask, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (wmask)
            WM_BYTE: m = 4'b0001 << off;
            WM_HALF: m = 4'b0011 << off;
            WM_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Unknown width codes are reported as misaligned.
    function automatic logic is_misaligned(input logic [2:0] wmask, input logic [1:0] off);
        logic r;
        r = 1'b1;
        case (wmask)
            WM_BYTE: r = 1'b0;
            WM_HALF: r = off[0];
            WM_WORD: r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_24090003_sram_array.sv
// Byte-enabled 32-bit storage: synchronous write, combinational read by index.
module ysyx_24090003_sram_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = 12
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_24090003_dmem_responder.sv
// Single-outstanding data-memory responder with fixed latency and fault reporting.
module ysyx_24090003_dmem_responder
    import ysyx_24090003_dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_mem_addr,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_mem_wmask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [32:0] TOP_EXT  = BASE_EXT + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pend_rdata_q;
    logic        pend_err_q;

    logic             accept_c;
    logic             in_range_c;
    logic             req_err_c;
    logic [IDX_W-1:0] idx_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_shift_c;
    logic [31:0]      sram_rdata_c;
    logic [31:0]      rsp_rdata_c;

    // 33-bit compare keeps the top of memory from wrapping past 2^32.
    assign in_range_c    = ({1'b0, i_mem_addr} >= BASE_EXT) && ({1'b0, i_mem_addr} < TOP_EXT);
    assign req_err_c     = !in_range_c || is_misaligned(i_mem_wmask, i_mem_addr[1:0]);
    assign idx_c         = IDX_W'((i_mem_addr - BASE_ADDR) >> 2);
    assign accept_c      = i_req_valid && o_req_ready;
    assign wdata_shift_c = i_mem_wdata << {i_mem_addr[1:0], 3'b000};
    assign be_c          = (accept_c && i_mem_we && !req_err_c)
                           ? lane_mask(i_mem_wmask, i_mem_addr[1:0]) : 4'b0000;
    assign rsp_rdata_c   = (req_err_c || i_mem_we) ? 32'h0 : sram_rdata_c;

    ysyx_24090003_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk  (i_clk),
        .idx  (idx_c),
        .be   (be_c),
        .wdata(wdata_shift_c),
        .rdata(sram_rdata_c)
    );

    // Request/response FSM; the response is captured at acceptance and released after LATENCY edges.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            pend_rdata_q <= 32'h0;
            pend_err_q   <= 1'b0;
            o_req_ready  <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_mem_rdata  <= 32'h0;
            o_rsp_err    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    o_req_ready <= 1'b1;
                    if (accept_c) begin
                        o_req_ready  <= 1'b0;
                        pend_rdata_q <= rsp_rdata_c;
                        pend_err_q   <= req_err_c;
                        if (LATENCY <= 1) begin
                            state_q     <= ST_RESP;
                            o_rsp_valid <= 1'b1;
                            o_mem_rdata <= rsp_rdata_c;
                            o_rsp_err   <= req_err_c;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= ST_RESP;
                        o_rsp_valid <= 1'b1;
                        o_mem_rdata <= pend_rdata_q;
                        o_rsp_err   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Ready reasserts for the next cycle only, never during the handshake itself.
                    if (i_rsp_ready) begin
                        state_q     <= ST_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_mem_rdata <= 32'h0;
                        o_rsp_err   <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    o_req_ready <= 1'b0;
                    o_rsp_valid <= 1'b0;
                    o_mem_rdata <= 32'h0;
                    o_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_dmem_responder.sv
// Directed bench for the data-memory responder at LATENCY=3.
module tb_ysyx_24090003_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] mem_rdata;
    logic        rsp_err;

    int checks = 0;
    int passes = 0;

    ysyx_24090003_dmem_responder #(
        .BASE_ADDR  (32'h8000_0000),
        .DEPTH_WORDS(4096),
        .LATENCY    (3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_mem_addr (mem_addr),
        .i_mem_we   (mem_we),
        .i_mem_wdata(mem_wdata),
        .i_mem_wmask(mem_wmask),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_mem_rdata(mem_rdata),
        .o_rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_req(input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [2:0] wmask);
        @(negedge clk);
        mem_addr  = addr;
        mem_we    = we;
        mem_wdata = wdata;
        mem_wmask = wmask;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid; counts samples where ready or idle outputs misbehave.
    task automatic wait_rsp(output int lat, output int idle_bad);
        lat = -1;
        idle_bad = 0;
        if (rsp_valid) lat = 0;
        else begin
            if (req_ready !== 1'b0 || mem_rdata !== 32'h0 || rsp_err !== 1'b0) idle_bad++;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (rsp_valid) begin
                    lat = k;
                    break;
                end
                if (req_ready !== 1'b0 || mem_rdata !== 32'h0 || rsp_err !== 1'b0) idle_bad++;
            end
        end
        checks++;
        if (lat < 0) $display("FAIL rsp_timeout got no rsp_valid want within 20 cycles");
        else passes++;
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [2:0] wmask, output logic [31:0] rdata,
                          output logic err, output int lat);
        int idle_bad;
        send_req(addr, we, wdata, wmask);
        wait_rsp(lat, idle_bad);
        rdata = mem_rdata;
        err   = rsp_err;
        finish_rsp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (mem_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", mem_rdata); else passes++;
        checks++; if (rsp_err !== 1'b0) $display("FAIL rst_err got %b want 0", rsp_err); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else passes++;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3'b111, rd, er, lat);
        checks++; if (lat !== 3) $display("FAIL word_wr_lat got %0d want 3", lat); else passes++;
        checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL word_wr_rsp got %h/%b want 00000000/0", rd, er); else passes++;
        do_req(32'h8000_0010, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL word_rd_data got %h want deadbeef", rd); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL word_rd_err got %b want 0", er); else passes++;
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(32'h8000_0000, 1'b1, 32'h1122_3344, 3'b111, rd, er, lat);
        do_req(32'h8000_0002, 1'b1, 32'h0000_00AA, 3'b001, rd, er, lat);
        checks++; if (er !== 1'b0) $display("FAIL byte_wr_err got %b want 0", er); else passes++;
        do_req(32'h8000_0000, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (rd !== 32'h11AA_3344) $display("FAIL byte_merge got %h want 11aa3344", rd); else passes++;
        do_req(32'h8000_0020, 1'b1, 32'h0, 3'b111, rd, er, lat);
        do_req(32'h8000_0022, 1'b1, 32'h0000_5566, 3'b011, rd, er, lat);
        do_req(32'h8000_0022, 1'b0, 32'h0, 3'b011, rd, er, lat);
        checks++; if (rd !== 32'h5566_0000 || er !== 1'b0) $display("FAIL half_merge got %h/%b want 55660000/0", rd, er); else passes++;
    endtask

    task automatic test_backpressure();
        int lat;
        int idle_bad;
        int hold_bad = 0;
        send_req(32'h8000_0010, 1'b0, 32'h0, 3'b111);
        wait_rsp(lat, idle_bad);
        checks++; if (lat !== 3) $display("FAIL bp_lat got %0d want 3", lat); else passes++;
        checks++; if (idle_bad !== 0) $display("FAIL bp_wait_outputs got %0d bad samples want 0", idle_bad); else passes++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || req_ready !== 1'b0)
                hold_bad++;
        end
        checks++; if (hold_bad !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad); else passes++;
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0 || mem_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL bp_after got %b/%h/%b want 0/00000000/0", rsp_valid, mem_rdata, rsp_err); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", req_ready); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int idle_bad;
        send_req(32'h8000_0010, 1'b0, 32'h0, 3'b111);
        wait_rsp(lat, idle_bad);
        // Offer the next request in the handshake cycle; it must wait one cycle.
        @(negedge clk);
        rsp_ready = 1'b1;
        mem_addr  = 32'h8000_0000;
        mem_we    = 1'b0;
        mem_wmask = 3'b111;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL b2b_not_same_cycle got ready=%b valid=%b want 1/0", req_ready, rsp_valid); else passes++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) $display("FAIL b2b_accept got ready=%b want 0", req_ready); else passes++;
        wait_rsp(lat, idle_bad);
        checks++; if (lat !== 3) $display("FAIL b2b_lat got %0d want 3", lat); else passes++;
        checks++; if (mem_rdata !== 32'h11AA_3344) $display("FAIL b2b_data got %h want 11aa3344", mem_rdata); else passes++;
        finish_rsp();
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(32'h8000_3FFC, 1'b1, 32'h1234_5678, 3'b111, rd, er, lat);
        checks++; if (er !== 1'b0) $display("FAIL top_word_wr_err got %b want 0", er); else passes++;
        do_req(32'h8000_0001, 1'b0, 32'h0, 3'b011, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL half_misalign got %h/%b want 00000000/1", rd, er); else passes++;
        do_req(32'h7FFF_FFFC, 1'b1, 32'hCAFE_F00D, 3'b111, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL below_base_wr got %h/%b want 00000000/1", rd, er); else passes++;
        checks++; if (lat !== 3) $display("FAIL err_lat got %0d want 3", lat); else passes++;
        do_req(32'h8000_3FFC, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) $display("FAIL top_word_unchanged got %h/%b want 12345678/0", rd, er); else passes++;
        do_req(32'h8000_4000, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL past_top_rd got %h/%b want 00000000/1", rd, er); else passes++;
        do_req(32'hFFFF_FFFC, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (er !== 1'b1) $display("FAIL addr_max_rd got %b want 1", er); else passes++;
        do_req(32'h8000_0000, 1'b0, 32'h0, 3'b010, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL bad_wmask got %h/%b want 00000000/1", rd, er); else passes++;
        do_req(32'h8000_0012, 1'b1, 32'hFFFF_FFFF, 3'b111, rd, er, lat);
        checks++; if (er !== 1'b1) $display("FAIL word_misalign_wr got %b want 1", er); else passes++;
        do_req(32'h8000_0010, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL misalign_no_write got %h want deadbeef", rd); else passes++;
        do_req(32'h8000_0013, 1'b0, 32'h0, 3'b001, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) $display("FAIL byte_odd_rd got %h/%b want deadbeef/0", rd, er); else passes++;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          late_valid = 0;
        send_req(32'h8000_0030, 1'b1, 32'hA5A5_5A5A, 3'b111);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL wait_rst got valid=%b ready=%b want 0/0", rsp_valid, req_ready); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL wait_rst_ready got %b want 1", req_ready); else passes++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) late_valid++;
        end
        checks++; if (late_valid !== 0) $display("FAIL wait_rst_dropped got %0d valid cycles want 0", late_valid); else passes++;
        do_req(32'h8000_0030, 1'b0, 32'h0, 3'b111, rd, er, lat);
        checks++; if (rd !== 32'hA5A5_5A5A || er !== 1'b0) $display("FAIL wait_rst_committed got %h/%b want a5a55a5a/0", rd, er); else passes++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        mem_wmask = 3'b111;
        rsp_ready = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
